// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding and widths.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    STALL_RUN      = 2'd0,
    STALL_MEM_WAIT = 2'd1,
    STALL_FLUSH    = 2'd2
  } stall_state_t;

  localparam int DEFAULT_CNT_WIDTH = 16;
  localparam int MEM_TIMEOUT_W     = 8;
  localparam int FLUSH_REM_W       = 3;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-side requests into the stall controller and the pipeline-register controls it returns.
interface pipeline_stall_controller_if;

  logic hazard_detected;
  logic branch_taken;
  logic mem_busy;
  logic freeze_PC;
  logic freeze_IF_ID;
  logic bubble_ID_EXE;
  logic freeze_EXE_MEM;
  logic bubble_MEM_WB;
  logic flush_IF_ID;

  modport master (
    output hazard_detected, branch_taken, mem_busy,
    input  freeze_PC, freeze_IF_ID, bubble_ID_EXE, freeze_EXE_MEM, bubble_MEM_WB, flush_IF_ID
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_busy,
    output freeze_PC, freeze_IF_ID, bubble_ID_EXE, freeze_EXE_MEM, bubble_MEM_WB, flush_IF_ID
  );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the performance counters; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count one per enabled cycle, holding at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: Mealy freeze/bubble/flush generation, memory-wait FSM,
// post-branch flush window, sticky memory watchdog and saturating performance counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int FLUSH_DEPTH = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_stall_controller_if.slave  hz,
  output logic                        mem_timeout,
  output logic [1:0]                  state_out,
  output logic [CNT_WIDTH-1:0]        stall_cnt,
  output logic [CNT_WIDTH-1:0]        memwait_cnt,
  output logic [CNT_WIDTH-1:0]        flush_cnt
);

  localparam logic [MEM_TIMEOUT_W-1:0] TIMEOUT_V = MEM_TIMEOUT_W'(MEM_TIMEOUT);
  localparam logic [FLUSH_REM_W-1:0]   FLUSH_REM = FLUSH_REM_W'(FLUSH_DEPTH - 1);

  stall_state_t             state_q, state_d;
  logic [MEM_TIMEOUT_W-1:0] wait_q, wait_d;
  logic [FLUSH_REM_W-1:0]   rem_q, rem_d;
  logic                     timeout_set;
  logic                     inc_stall, inc_memwait, inc_flush;
  logic                     frz_pc, frz_if_id, bub_id_exe, frz_exe_mem, bub_mem_wb, flush_if_id;

  // State register with wait/flush-window counters and the sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STALL_RUN;
      wait_q      <= '0;
      rem_q       <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rem_q   <= rem_d;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Next-state logic; the watchdog trips on the edge where the wait count reaches the limit.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    rem_d       = rem_q;
    timeout_set = 1'b0;
    case (state_q)
      STALL_RUN, STALL_MEM_WAIT: begin
        if (hz.mem_busy) begin
          state_d = STALL_MEM_WAIT;
          if (state_q == STALL_RUN) begin
            wait_d = MEM_TIMEOUT_W'(1);
          end else if (wait_q != TIMEOUT_V) begin
            wait_d = wait_q + MEM_TIMEOUT_W'(1);
          end
          timeout_set = (wait_d == TIMEOUT_V);
        end else begin
          wait_d  = '0;
          state_d = STALL_RUN;
          if (hz.branch_taken && (FLUSH_DEPTH > 1)) begin
            state_d = STALL_FLUSH;
            rem_d   = FLUSH_REM;
          end
        end
      end
      STALL_FLUSH: begin
        // A memory stall pauses the flush window without consuming it.
        if (!hz.mem_busy) begin
          rem_d = rem_q - FLUSH_REM_W'(1);
          if (rem_q <= FLUSH_REM_W'(1)) begin
            state_d = STALL_RUN;
          end
        end
      end
      default: begin
        state_d = STALL_RUN;
      end
    endcase
  end

  // Mealy control outputs and counter enables; priority mem_busy > branch_taken > hazard_detected.
  always_comb begin
    frz_pc      = 1'b0;
    frz_if_id   = 1'b0;
    bub_id_exe  = 1'b0;
    frz_exe_mem = 1'b0;
    bub_mem_wb  = 1'b0;
    flush_if_id = 1'b0;
    inc_stall   = 1'b0;
    inc_memwait = 1'b0;
    inc_flush   = 1'b0;
    case (state_q)
      STALL_RUN, STALL_MEM_WAIT: begin
        if (hz.mem_busy) begin
          frz_pc      = 1'b1;
          frz_if_id   = 1'b1;
          frz_exe_mem = 1'b1;
          bub_mem_wb  = 1'b1;
          inc_memwait = 1'b1;
        end else if (hz.branch_taken) begin
          flush_if_id = 1'b1;
          inc_flush   = 1'b1;
        end else if (hz.hazard_detected) begin
          frz_pc      = 1'b1;
          frz_if_id   = 1'b1;
          bub_id_exe  = 1'b1;
          inc_stall   = 1'b1;
        end
      end
      STALL_FLUSH: begin
        // Hazards and repeat branches are dead instructions inside the flush window.
        if (hz.mem_busy) begin
          frz_pc      = 1'b1;
          frz_if_id   = 1'b1;
          frz_exe_mem = 1'b1;
          bub_mem_wb  = 1'b1;
        end else begin
          flush_if_id = 1'b1;
        end
      end
      default: begin
        frz_pc = 1'b0;
      end
    endcase
  end

  assign hz.freeze_PC      = frz_pc;
  assign hz.freeze_IF_ID   = frz_if_id;
  assign hz.bubble_ID_EXE  = bub_id_exe;
  assign hz.freeze_EXE_MEM = frz_exe_mem;
  assign hz.bubble_MEM_WB  = bub_mem_wb;
  assign hz.flush_IF_ID    = flush_if_id;
  assign state_out         = state_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(inc_stall), .count(stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_memwait_cnt (
    .clk(clk), .rst(rst), .inc(inc_memwait), .count(memwait_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(inc_flush), .count(flush_cnt)
  );

endmodule
